// File: rtl/ysyx_22041461_exe_mem_buf.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041461_exe_mem_buf
// Brief    : Two-entry skid buffer between EXE and MEM with one-shot store
//            strobe and flush. Optional bypass tap: YSYX_22041461_EXEMEM_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041461_exe_mem_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        EXE_valid,
    output logic        EXE_ready,
    input  logic [63:0] EXE_result,
    input  logic [63:0] EXE_rs2_data,
    input  logic [3:0]  EXE_mem_ctrl,
    input  logic [4:0]  EXE_rd,
    input  logic        EXE_rd_wen,
    input  logic        MEM_ready,
    output logic        MEM_valid,
    output logic        MEM_write_valid,
    output logic [63:0] MEM_EXE_in,
    output logic [63:0] MEM_rs2_data,
    output logic [3:0]  MEM_ctrl,
    output logic [4:0]  MEM_rd,
    output logic        MEM_rd_wen,
    output logic        fwd_valid,
    output logic        fwd_is_load,
    output logic [4:0]  fwd_rd,
    output logic [63:0] fwd_data
);

    // Memory op codes, mirroring the core's MEM_* macro encoding
    localparam logic [3:0] c_MEM_NONE = 4'd0;
    localparam logic [3:0] c_MEM_LB   = 4'd1;
    localparam logic [3:0] c_MEM_LH   = 4'd2;
    localparam logic [3:0] c_MEM_LW   = 4'd3;
    localparam logic [3:0] c_MEM_LD   = 4'd4;
    localparam logic [3:0] c_MEM_LBU  = 4'd5;
    localparam logic [3:0] c_MEM_LHU  = 4'd6;
    localparam logic [3:0] c_MEM_LWU  = 4'd7;
    localparam logic [3:0] c_MEM_SB   = 4'd8;
    localparam logic [3:0] c_MEM_SH   = 4'd9;
    localparam logic [3:0] c_MEM_SW   = 4'd10;
    localparam logic [3:0] c_MEM_SD   = 4'd11;

    logic        r_h_valid;
    logic [63:0] r_h_result;
    logic [63:0] r_h_rs2;
    logic [3:0]  r_h_ctrl;
    logic [4:0]  r_h_rd;
    logic        r_h_rd_wen;

    logic        r_s_valid;
    logic [63:0] r_s_result;
    logic [63:0] r_s_rs2;
    logic [3:0]  r_s_ctrl;
    logic [4:0]  r_s_rd;
    logic        r_s_rd_wen;

    logic        w_accept;
    logic        w_pop;
    logic        w_h_is_store;

    assign EXE_ready = !r_s_valid;
    assign w_accept  = EXE_valid && !r_s_valid;
    assign w_pop     = r_h_valid && MEM_ready;

    always_comb begin
        w_h_is_store = 1'b0;
        case (r_h_ctrl)
            c_MEM_SB, c_MEM_SH, c_MEM_SW, c_MEM_SD: w_h_is_store = 1'b1;
            default:                                w_h_is_store = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_valid  <= 1'b0;
            r_h_result <= 64'd0;
            r_h_rs2    <= 64'd0;
            r_h_ctrl   <= c_MEM_NONE;
            r_h_rd     <= 5'd0;
            r_h_rd_wen <= 1'b0;
            r_s_valid  <= 1'b0;
            r_s_result <= 64'd0;
            r_s_rs2    <= 64'd0;
            r_s_ctrl   <= c_MEM_NONE;
            r_s_rd     <= 5'd0;
            r_s_rd_wen <= 1'b0;
        end else if (flush) begin
            // Payloads are left untouched; only the valid bits are killed.
            r_h_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_h_valid) begin
            if (w_accept) begin
                r_h_valid  <= 1'b1;
                r_h_result <= EXE_result;
                r_h_rs2    <= EXE_rs2_data;
                r_h_ctrl   <= EXE_mem_ctrl;
                r_h_rd     <= EXE_rd;
                r_h_rd_wen <= EXE_rd_wen;
            end
        end else if (!r_s_valid) begin
            if (w_accept && w_pop) begin
                r_h_result <= EXE_result;
                r_h_rs2    <= EXE_rs2_data;
                r_h_ctrl   <= EXE_mem_ctrl;
                r_h_rd     <= EXE_rd;
                r_h_rd_wen <= EXE_rd_wen;
            end else if (w_accept) begin
                r_s_valid  <= 1'b1;
                r_s_result <= EXE_result;
                r_s_rs2    <= EXE_rs2_data;
                r_s_ctrl   <= EXE_mem_ctrl;
                r_s_rd     <= EXE_rd;
                r_s_rd_wen <= EXE_rd_wen;
            end else if (w_pop) begin
                r_h_valid <= 1'b0;
            end
        end else if (w_pop) begin
            r_s_valid  <= 1'b0;
            r_h_result <= r_s_result;
            r_h_rs2    <= r_s_rs2;
            r_h_ctrl   <= r_s_ctrl;
            r_h_rd     <= r_s_rd;
            r_h_rd_wen <= r_s_rd_wen;
        end
    end

    assign MEM_valid    = r_h_valid;
    assign MEM_EXE_in   = r_h_result;
    assign MEM_rs2_data = r_h_rs2;
    assign MEM_ctrl     = r_h_ctrl;
    assign MEM_rd       = r_h_rd;
    assign MEM_rd_wen   = r_h_rd_wen;

    // Strobe only in the pop cycle, so a stalled store cannot write twice.
    assign MEM_write_valid = r_h_valid && MEM_ready && !flush && !rst && w_h_is_store;

`ifdef YSYX_22041461_EXEMEM_FWD_EN
    logic w_h_is_load;

    always_comb begin
        w_h_is_load = 1'b0;
        case (r_h_ctrl)
            c_MEM_LB, c_MEM_LH, c_MEM_LW, c_MEM_LD,
            c_MEM_LBU, c_MEM_LHU, c_MEM_LWU: w_h_is_load = 1'b1;
            default:                         w_h_is_load = 1'b0;
        endcase
    end

    assign fwd_valid   = r_h_valid && r_h_rd_wen && (r_h_rd != 5'd0);
    assign fwd_is_load = w_h_is_load;
    assign fwd_rd      = r_h_rd;
    assign fwd_data    = r_h_result;
`else
    assign fwd_valid   = 1'b0;
    assign fwd_is_load = 1'b0;
    assign fwd_rd      = 5'd0;
    assign fwd_data    = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041461_exe_mem_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041461_exe_mem_buf
// Brief    : Directed + random checks of the EXE/MEM skid buffer against a
//            queue model of the buffer contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041461_exe_mem_buf;

    localparam logic [3:0] c_LB = 4'd1, c_LH = 4'd2, c_LW = 4'd3, c_LD = 4'd4;
    localparam logic [3:0] c_LBU = 4'd5, c_LHU = 4'd6, c_LWU = 4'd7;
    localparam logic [3:0] c_SB = 4'd8, c_SH = 4'd9, c_SW = 4'd10, c_SD = 4'd11;

    logic        clk = 1'b0;
    logic        rst, flush, EXE_valid, EXE_rd_wen, MEM_ready;
    logic [63:0] EXE_result, EXE_rs2_data;
    logic [3:0]  EXE_mem_ctrl;
    logic [4:0]  EXE_rd;
    logic        EXE_ready, MEM_valid, MEM_write_valid, MEM_rd_wen;
    logic [63:0] MEM_EXE_in, MEM_rs2_data, fwd_data;
    logic [3:0]  MEM_ctrl;
    logic [4:0]  MEM_rd, fwd_rd;
    logic        fwd_valid, fwd_is_load;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] rs2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wen;
    } ent_t;

    ent_t q[$];
    ent_t hold;

    always #5 clk = ~clk;

    ysyx_22041461_exe_mem_buf dut (
        .clk(clk), .rst(rst), .flush(flush),
        .EXE_valid(EXE_valid), .EXE_ready(EXE_ready),
        .EXE_result(EXE_result), .EXE_rs2_data(EXE_rs2_data),
        .EXE_mem_ctrl(EXE_mem_ctrl), .EXE_rd(EXE_rd), .EXE_rd_wen(EXE_rd_wen),
        .MEM_ready(MEM_ready), .MEM_valid(MEM_valid),
        .MEM_write_valid(MEM_write_valid), .MEM_EXE_in(MEM_EXE_in),
        .MEM_rs2_data(MEM_rs2_data), .MEM_ctrl(MEM_ctrl), .MEM_rd(MEM_rd),
        .MEM_rd_wen(MEM_rd_wen), .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    function automatic logic is_store(logic [3:0] c);
        return (c == c_SB) || (c == c_SH) || (c == c_SW) || (c == c_SD);
    endfunction

    function automatic logic is_load(logic [3:0] c);
        return (c == c_LB) || (c == c_LH) || (c == c_LW) || (c == c_LD) ||
               (c == c_LBU) || (c == c_LHU) || (c == c_LWU);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        ent_t h;
        logic hv;
        hv = (q.size() > 0);
        h  = hv ? q[0] : hold;
        chk("EXE_ready", 64'(EXE_ready), 64'(q.size() < 2));
        chk("MEM_valid", 64'(MEM_valid), 64'(hv));
        chk("MEM_write_valid", 64'(MEM_write_valid),
            64'(hv && MEM_ready && !flush && !rst && is_store(h.ctrl)));
        chk("MEM_EXE_in", MEM_EXE_in, h.res);
        chk("MEM_rs2_data", MEM_rs2_data, h.rs2);
        chk("MEM_ctrl", 64'(MEM_ctrl), 64'(h.ctrl));
        chk("MEM_rd", 64'(MEM_rd), 64'(h.rd));
        chk("MEM_rd_wen", 64'(MEM_rd_wen), 64'(h.wen));
`ifdef YSYX_22041461_EXEMEM_FWD_EN
        chk("fwd_valid", 64'(fwd_valid), 64'(hv && h.wen && (h.rd != 5'd0)));
        chk("fwd_is_load", 64'(fwd_is_load), 64'(is_load(h.ctrl)));
        chk("fwd_rd", 64'(fwd_rd), 64'(h.rd));
        chk("fwd_data", fwd_data, h.res);
`else
        chk("fwd_valid", 64'(fwd_valid), 64'd0);
        chk("fwd_is_load", 64'(fwd_is_load), 64'd0);
        chk("fwd_rd", 64'(fwd_rd), 64'd0);
        chk("fwd_data", fwd_data, 64'd0);
`endif
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic update_model();
        logic acc, pop;
        if (rst) begin
            q.delete();
            hold = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = EXE_valid && (q.size() < 2);
            pop = (q.size() > 0) && MEM_ready;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back({EXE_result, EXE_rs2_data, EXE_mem_ctrl, EXE_rd, EXE_rd_wen});
        end
        if (q.size() > 0) hold = q[0];
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic tick();
        #1;
        compare_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [63:0] r,
                         input logic [63:0] d, input logic [4:0] rd, input logic w);
        EXE_valid = v; EXE_mem_ctrl = c; EXE_result = r;
        EXE_rs2_data = d; EXE_rd = rd; EXE_rd_wen = w;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; MEM_ready = 1'b0;
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        @(posedge clk);
        update_model();
        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;
        chk("reset MEM_valid", 64'(MEM_valid), 64'd0);
        chk("reset EXE_ready", 64'(EXE_ready), 64'd1);
        chk("reset MEM_ctrl", 64'(MEM_ctrl), 64'd0);
        chk("reset MEM_rd_wen", 64'(MEM_rd_wen), 64'd0);

        // Single store with MEM ready: one strobe, then empty
        drive(1'b1, c_SD, 64'h8000_0008, 64'h1122334455667788, 5'd0, 1'b0);
        MEM_ready = 1'b1;
        tick();
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        #1;
        chk("sd MEM_valid", 64'(MEM_valid), 64'd1);
        chk("sd write_valid", 64'(MEM_write_valid), 64'd1);
        chk("sd addr", MEM_EXE_in, 64'h8000_0008);
        chk("sd data", MEM_rs2_data, 64'h1122334455667788);
        tick();
        #1;
        chk("sd after pop valid", 64'(MEM_valid), 64'd0);
        chk("sd after pop strobe", 64'(MEM_write_valid), 64'd0);

        // Stalled SW: no strobe for 3 cycles, EXE_ready drops in FULL
        MEM_ready = 1'b0;
        drive(1'b1, c_SW, 64'h100, 64'hAA, 5'd0, 1'b0);
        tick();
        drive(1'b1, c_LD, 64'h200, 64'hBB, 5'd7, 1'b1);
        #1;
        chk("sw stall1 strobe", 64'(MEM_write_valid), 64'd0);
        tick();
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        #1;
        chk("sw stall2 strobe", 64'(MEM_write_valid), 64'd0);
        chk("full EXE_ready", 64'(EXE_ready), 64'd0);
        tick();
        #1;
        chk("sw stall3 strobe", 64'(MEM_write_valid), 64'd0);
        MEM_ready = 1'b1;
        #1;
        chk("sw pop strobe", 64'(MEM_write_valid), 64'd1);
        tick();
        #1;
        chk("after pop EXE_ready", 64'(EXE_ready), 64'd1);
        chk("ld head result", MEM_EXE_in, 64'h200);
        chk("ld no strobe", 64'(MEM_write_valid), 64'd0);
        tick();

        // FULL with SB head, flush + MEM_ready: no strobe, then empty
        MEM_ready = 1'b0;
        drive(1'b1, c_SB, 64'h300, 64'h5, 5'd0, 1'b0);
        tick();
        drive(1'b1, c_SH, 64'h308, 64'h6, 5'd0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        flush = 1'b1; MEM_ready = 1'b1;
        #1;
        chk("flush strobe", 64'(MEM_write_valid), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush MEM_valid", 64'(MEM_valid), 64'd0);
        chk("flush EXE_ready", 64'(EXE_ready), 64'd1);

        // Reset while FULL
        MEM_ready = 1'b0;
        drive(1'b1, c_SD, 64'h400, 64'h7, 5'd3, 1'b1);
        tick();
        tick();
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        rst = 1'b1; MEM_ready = 1'b1;
        #1;
        chk("rst strobe", 64'(MEM_write_valid), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst MEM_valid", 64'(MEM_valid), 64'd0);
        chk("rst EXE_ready", 64'(EXE_ready), 64'd1);
        chk("rst MEM_ctrl", 64'(MEM_ctrl), 64'd0);

        // Bypass tap on a load head
        MEM_ready = 1'b0;
        drive(1'b1, c_LW, 64'h1234, 64'd0, 5'd5, 1'b1);
        tick();
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        #1;
`ifdef YSYX_22041461_EXEMEM_FWD_EN
        chk("fwd lw valid", 64'(fwd_valid), 64'd1);
        chk("fwd lw rd", 64'(fwd_rd), 64'd5);
        chk("fwd lw is_load", 64'(fwd_is_load), 64'd1);
        chk("fwd lw data", fwd_data, 64'h1234);
`else
        chk("nofwd valid", 64'(fwd_valid), 64'd0);
        chk("nofwd rd", 64'(fwd_rd), 64'd0);
        chk("nofwd is_load", 64'(fwd_is_load), 64'd0);
`endif
        MEM_ready = 1'b1;
        drive(1'b1, c_LW, 64'h1234, 64'd0, 5'd0, 1'b1);
        tick();
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        #1;
        chk("fwd rd0 valid", 64'(fwd_valid), 64'd0);
        tick();

        // Random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 4);
            MEM_ready = ($urandom_range(0, 99) < 60);
            drive(($urandom_range(0, 99) < 70), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
